// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for Pong.
// Runs the serve / play / pause / point / game-over sequence, keeps both
// scores and gates ball motion for the per-frame physics logic.
module pong_match_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_in,
    input  logic       pause_in,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       phys_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        POINT     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [3:0] WIN_VALUE  = 4'(WIN_SCORE);
    localparam logic [6:0] SERVE_LAST = 7'(SERVE_FRAMES - 1);
    localparam logic [6:0] POINT_LAST = 7'(POINT_FRAMES - 1);

    state_t     state;
    state_t     state_next;
    logic [6:0] frame_cnt;
    logic [6:0] frame_cnt_next;
    logic [3:0] score_l_next;
    logic [3:0] score_r_next;
    logic       serve_dir_next;
    logic       winner_next;
    logic       ball_reset_next;

    // Edge-detect history. edge_valid stays low for the first clock after
    // reset so that a button already held during reset release is not
    // mistaken for a fresh press (the history registers reset to 0).
    logic       start_q;
    logic       pause_q;
    logic       edge_valid;
    logic       start_rise;
    logic       pause_rise;

    logic [3:0] score_l_inc;
    logic [3:0] score_r_inc;

    assign start_rise = start_in & ~start_q & edge_valid;
    assign pause_rise = pause_in & ~pause_q & edge_valid;

    // Scores stick at 15 rather than wrapping back to zero.
    assign score_l_inc = (score_l == 4'hF) ? 4'hF : score_l + 4'd1;
    assign score_r_inc = (score_r == 4'hF) ? 4'hF : score_r + 4'd1;

    // Status outputs are plain decodes of the registered state.
    assign phys_run  = (state == PLAY);
    assign game_over = (state == GAME_OVER);
    assign state_o   = state;

    // Button history registers used for rising-edge detection.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            start_q    <= 1'b0;
            pause_q    <= 1'b0;
            edge_valid <= 1'b0;
        end else begin
            start_q    <= start_in;
            pause_q    <= pause_in;
            edge_valid <= 1'b1;
        end
    end

    // Next-state, frame counter, score and serve bookkeeping for the match.
    always_comb begin
        state_next      = state;
        frame_cnt_next  = frame_cnt;
        score_l_next    = score_l;
        score_r_next    = score_r;
        serve_dir_next  = serve_dir;
        winner_next     = winner;
        ball_reset_next = 1'b0;

        case (state)
            IDLE: begin
                if (start_rise) begin
                    score_l_next    = 4'd0;
                    score_r_next    = 4'd0;
                    serve_dir_next  = 1'b1;
                    ball_reset_next = 1'b1;
                    state_next      = SERVE;
                end
            end

            SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt == SERVE_LAST) begin
                        state_next = PLAY;
                    end else begin
                        frame_cnt_next = frame_cnt + 7'd1;
                    end
                end
            end

            PLAY: begin
                if (miss_left) begin
                    score_r_next   = score_r_inc;
                    serve_dir_next = 1'b0;
                    if (score_r_inc == WIN_VALUE) begin
                        winner_next = 1'b1;
                        state_next  = GAME_OVER;
                    end else begin
                        state_next  = POINT;
                    end
                end else if (miss_right) begin
                    score_l_next   = score_l_inc;
                    serve_dir_next = 1'b1;
                    if (score_l_inc == WIN_VALUE) begin
                        winner_next = 1'b0;
                        state_next  = GAME_OVER;
                    end else begin
                        state_next  = POINT;
                    end
                end else if (pause_rise) begin
                    state_next = PAUSED;
                end
            end

            PAUSED: begin
                if (pause_rise) begin
                    state_next = PLAY;
                end
            end

            POINT: begin
                if (frame_tick) begin
                    if (frame_cnt == POINT_LAST) begin
                        ball_reset_next = 1'b1;
                        state_next      = SERVE;
                    end else begin
                        frame_cnt_next = frame_cnt + 7'd1;
                    end
                end
            end

            GAME_OVER: begin
                if (start_rise) begin
                    score_l_next    = 4'd0;
                    score_r_next    = 4'd0;
                    winner_next     = 1'b0;
                    serve_dir_next  = 1'b1;
                    ball_reset_next = 1'b1;
                    state_next      = SERVE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Every state starts its frame count from zero.
        if (state_next != state) begin
            frame_cnt_next = 7'd0;
        end
    end

    // Match state and bookkeeping registers.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_cnt  <= 7'd0;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            serve_dir  <= 1'b1;
            winner     <= 1'b0;
            ball_reset <= 1'b0;
        end else begin
            state      <= state_next;
            frame_cnt  <= frame_cnt_next;
            score_l    <= score_l_next;
            score_r    <= score_r_next;
            serve_dir  <= serve_dir_next;
            winner     <= winner_next;
            ball_reset <= ball_reset_next;
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed self-checking bench for pong_match_ctrl.
// Inputs change just after the falling edge; outputs are checked on the
// following falling edge, half a cycle after the rising edge that acted.
module tb_pong_match_ctrl;

    logic       vga_clk;
    logic       reset;
    logic       frame_tick;
    logic       start_in;
    logic       pause_in;
    logic       miss_left;
    logic       miss_right;
    logic       phys_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       winner;
    logic [2:0] state_o;

    int errors;
    int checks;

    pong_match_ctrl #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (60),
        .POINT_FRAMES (90)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start_in   (start_in),
        .pause_in   (pause_in),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .phys_run   (phys_run),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner),
        .state_o    (state_o)
    );

    // Free-running pixel clock, 10 ns period.
    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // Compare one observed value with its expected value and log a mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the pulse inputs for one clock and land on the next falling edge.
    task automatic applyStimulus(input logic tick, input logic ml, input logic mr);
        frame_tick = tick;
        miss_left  = ml;
        miss_right = mr;
        @(negedge vga_clk);
        frame_tick = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    // Deliver n single-cycle frame ticks separated by one idle cycle.
    task automatic tickFrames(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Compare every output against its reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"},      state_o,    0);
        checkOutput({tag, "_phys_run"},   phys_run,   0);
        checkOutput({tag, "_ball_reset"}, ball_reset, 0);
        checkOutput({tag, "_serve_dir"},  serve_dir,  1);
        checkOutput({tag, "_score_l"},    score_l,    0);
        checkOutput({tag, "_score_r"},    score_r,    0);
        checkOutput({tag, "_game_over"},  game_over,  0);
        checkOutput({tag, "_winner"},     winner,     0);
    endtask

    // Directed match scenario.
    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        frame_tick = 1'b0;
        start_in   = 1'b0;
        pause_in   = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;

        repeat (3) @(negedge vga_clk);
        checkResetValues("por");
        reset = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_hold", state_o, 0);

        // Start rise: SERVE with a one-cycle ball_reset.
        start_in = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("start_state", state_o, 1);
        checkOutput("start_ball_reset", ball_reset, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("start_ball_reset_drop", ball_reset, 0);
        checkOutput("start_held_state", state_o, 1);
        start_in = 1'b0;

        // Serve length: 59 ticks still serving, the 60th enters PLAY.
        tickFrames(59);
        checkOutput("serve59_state", state_o, 1);
        checkOutput("serve59_phys", phys_run, 0);
        tickFrames(1);
        checkOutput("serve60_state", state_o, 2);
        checkOutput("serve60_phys", phys_run, 1);

        // Right edge miss: left scores, POINT.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mr_score_l", score_l, 1);
        checkOutput("mr_score_r", score_r, 0);
        checkOutput("mr_serve_dir", serve_dir, 1);
        checkOutput("mr_state", state_o, 4);
        checkOutput("mr_phys", phys_run, 0);

        // Point length: 89 ticks still in POINT, the 90th pulses ball_reset.
        tickFrames(89);
        checkOutput("point89_state", state_o, 4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("point90_state", state_o, 1);
        checkOutput("point90_ball_reset", ball_reset, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("point90_ball_reset_drop", ball_reset, 0);

        // Back to PLAY, then pause / miss-while-paused / resume.
        tickFrames(60);
        checkOutput("play2_state", state_o, 2);
        pause_in = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pause_state", state_o, 3);
        checkOutput("pause_phys", phys_run, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("paused_miss_score_r", score_r, 0);
        checkOutput("paused_miss_state", state_o, 3);
        pause_in = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        pause_in = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("resume_state", state_o, 2);
        checkOutput("resume_phys", phys_run, 1);
        pause_in = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Both misses and a pause rise together: miss_left wins.
        pause_in = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("prio_score_r", score_r, 1);
        checkOutput("prio_score_l", score_l, 1);
        checkOutput("prio_serve_dir", serve_dir, 0);
        checkOutput("prio_state", state_o, 4);
        pause_in = 1'b0;

        // Second right-player point.
        tickFrames(90);
        checkOutput("p2_serve_state", state_o, 1);
        tickFrames(60);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("p2_score_r", score_r, 2);
        checkOutput("p2_state", state_o, 4);

        // Third right-player point reaches WIN_SCORE = 3.
        tickFrames(90);
        tickFrames(60);
        checkOutput("p3_play_state", state_o, 2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("win_score_r", score_r, 3);
        checkOutput("win_score_l", score_l, 1);
        checkOutput("win_state", state_o, 5);
        checkOutput("win_game_over", game_over, 1);
        checkOutput("win_winner", winner, 1);
        checkOutput("win_phys", phys_run, 0);

        // Misses and ticks in GAME_OVER change nothing.
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("go_hold_score_l", score_l, 1);
        checkOutput("go_hold_state", state_o, 5);

        // Restart from GAME_OVER.
        start_in = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("restart_state", state_o, 1);
        checkOutput("restart_score_l", score_l, 0);
        checkOutput("restart_score_r", score_r, 0);
        checkOutput("restart_game_over", game_over, 0);
        checkOutput("restart_winner", winner, 0);
        checkOutput("restart_serve_dir", serve_dir, 1);
        checkOutput("restart_ball_reset", ball_reset, 1);
        start_in = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Get into POINT with 40 frames counted, then reset mid-cycle.
        tickFrames(60);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pre_rst_state", state_o, 4);
        tickFrames(40);
        #2;
        reset    = 1'b1;
        start_in = 1'b1;
        #1;
        checkOutput("async_rst_state", state_o, 0);
        @(negedge vga_clk);
        checkResetValues("midrst");

        // Start held high across reset release must not start a match.
        reset = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("held_start_state", state_o, 0);
        checkOutput("held_start_ball_reset", ball_reset, 0);
        start_in = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        start_in = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("fresh_start_state", state_o, 1);
        checkOutput("fresh_start_ball_reset", ball_reset, 1);
        start_in = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
